// File: rtl/dzcpu_trace_buffer_pkg.sv
// Shared definitions for the dzcpu trace buffer: state encodings, channel IDs
// and entry-width derivation helpers.
package dzcpu_trace_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_POST   = 2'd2,
      ST_FROZEN = 2'd3
   } trace_state_e;

   localparam int CH_CPU_EOF = 0;
   localparam int CH_MMU_WR  = 1;

   function automatic int chWidth(input int numCh);
      return (numCh > 1) ? $clog2(numCh) : 1;
   endfunction

   function automatic int entryWidth(input int tsW, input int numCh, input int dataW);
      return tsW + chWidth(numCh) + dataW;
   endfunction

endpackage

// File: rtl/dzcpu_trace_buffer_if.sv
// Control, event and read-port bundle of the trace buffer; the master drives
// the i* signals, the trace buffer (slave) drives the o* signals.
interface dzcpu_trace_buffer_if
   import dzcpu_trace_buffer_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int NUM_CH = 2,
   parameter int DATA_W = 32,
   parameter int TS_W   = 16
);
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int ENTRY_W = entryWidth(TS_W, NUM_CH, DATA_W);

   logic [NUM_CH-1:0]        iEvent;
   logic [NUM_CH*DATA_W-1:0] iPayload;
   logic                     iArm;
   logic                     iDisarm;
   logic                     iTrigger;
   logic [CNT_W-1:0]         iPostCount;
   logic                     iStopOnFull;
   logic                     iRdReq;
   logic [ENTRY_W-1:0]       oRdData;
   logic                     oRdValid;
   logic [CNT_W-1:0]         oCount;
   logic                     oEmpty;
   logic [1:0]               oState;
   logic                     oOverflow;
   logic                     oTriggered;
   logic [7:0]               oDropCount;

   modport master (
      output iEvent, iPayload, iArm, iDisarm, iTrigger, iPostCount, iStopOnFull, iRdReq,
      input  oRdData, oRdValid, oCount, oEmpty, oState, oOverflow, oTriggered, oDropCount
   );

   modport slave (
      input  iEvent, iPayload, iArm, iDisarm, iTrigger, iPostCount, iStopOnFull, iRdReq,
      output oRdData, oRdValid, oCount, oEmpty, oState, oOverflow, oTriggered, oDropCount
   );

endinterface

// File: rtl/dzcpu_trace_buffer_ram.sv
// Simple dual-port trace storage: one write port, registered read port with an
// output register that only updates on an accepted read.
module dzcpu_trace_buffer_ram #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 49
) (
   input  logic                     iClock,
   input  logic                     iReset,
   input  logic                     iWe,
   input  logic [$clog2(DEPTH)-1:0] iWaddr,
   input  logic [WIDTH-1:0]         iWdata,
   input  logic                     iRe,
   input  logic [$clog2(DEPTH)-1:0] iRaddr,
   output logic [WIDTH-1:0]         oRdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge iClock) begin
      if (iWe) mem[iWaddr] <= iWdata;
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset)   rdata_q <= '0;
      else if (iRe) rdata_q <= mem[iRaddr];
   end

   assign oRdata = rdata_q;

endmodule

// File: rtl/dzcpu_trace_buffer.sv
// Trace capture top: timestamp counter, lowest-index arbiter, trigger/post
// state machine, circular pointers and the pop-style read port.
module dzcpu_trace_buffer
   import dzcpu_trace_buffer_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int NUM_CH = 2,
   parameter int DATA_W = 32,
   parameter int TS_W   = 16
) (
   input logic                 iClock,
   input logic                 iReset,
   dzcpu_trace_buffer_if.slave bus
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int CH_W    = chWidth(NUM_CH);
   localparam int ENTRY_W = entryWidth(TS_W, NUM_CH, DATA_W);
   localparam int EVC_W   = $clog2(NUM_CH + 1);
   localparam int SUM_W   = EVC_W + 9;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   trace_state_e     state_q, state_d;
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d, postCnt_q, postCnt_d;
   logic [TS_W-1:0]  ts_q;
   logic             overflow_q, overflow_d, triggered_q, triggered_d, rdValid_q;
   logic [7:0]       drop_q, drop_d;

   logic              anyEvent;
   logic [CH_W-1:0]   winner;
   logic [DATA_W-1:0] winPayload;
   logic [EVC_W-1:0]  evCnt, losers;
   logic [SUM_W-1:0]  dropSum;
   logic              active, full, capWant, wrEn, rdAccept;
   logic [ENTRY_W-1:0] wrEntry;

   // Scanning downward leaves the lowest-index asserted channel as the winner.
   always_comb begin
      anyEvent   = 1'b0;
      winner     = '0;
      winPayload = '0;
      evCnt      = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (bus.iEvent[k]) begin
            anyEvent   = 1'b1;
            winner     = CH_W'(k);
            winPayload = bus.iPayload[k*DATA_W +: DATA_W];
         end
         evCnt = evCnt + EVC_W'(bus.iEvent[k]);
      end
      losers  = anyEvent ? evCnt - EVC_W'(1) : '0;
      dropSum = SUM_W'(drop_q) + SUM_W'(losers);
   end

   assign active   = (state_q == ST_ARMED) || (state_q == ST_POST);
   assign full     = (count_q == FULL_CNT);
   assign capWant  = active && anyEvent && !bus.iArm && !bus.iDisarm;
   assign wrEn     = capWant && !(full && bus.iStopOnFull);
   assign rdAccept = !bus.iArm && bus.iRdReq && (count_q != '0) &&
                     ((state_q == ST_IDLE) || (state_q == ST_FROZEN));
   assign wrEntry  = {ts_q, winner, winPayload};

   always_comb begin
      state_d     = state_q;
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      postCnt_d   = postCnt_q;
      overflow_d  = overflow_q;
      triggered_d = triggered_q;
      drop_d      = drop_q;
      if (bus.iArm) begin
         state_d     = ST_ARMED;
         wrPtr_d     = '0;
         rdPtr_d     = '0;
         count_d     = '0;
         postCnt_d   = '0;
         overflow_d  = 1'b0;
         triggered_d = 1'b0;
         drop_d      = '0;
      end else if (bus.iDisarm) begin
         state_d = ST_IDLE;
      end else begin
         if (active) drop_d = (dropSum > SUM_W'(255)) ? 8'hFF : dropSum[7:0];
         if (wrEn) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
            if (full) begin
               rdPtr_d    = rdPtr_q + PTR_W'(1);
               overflow_d = 1'b1;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         if (rdAccept) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
            count_d = count_q - CNT_W'(1);
         end
         case (state_q)
            ST_ARMED: if (bus.iTrigger) begin
               triggered_d = 1'b1;
               postCnt_d   = bus.iPostCount;
               state_d     = (bus.iPostCount == '0) ? ST_FROZEN : ST_POST;
            end
            ST_POST: if (wrEn) begin
               postCnt_d = postCnt_q - CNT_W'(1);
               if (postCnt_q == CNT_W'(1)) state_d = ST_FROZEN;
            end
            default: ;
         endcase
         // Stop mode keeps the write that fills the buffer, then freezes.
         if (capWant && bus.iStopOnFull && (full || count_q == FULL_CNT - CNT_W'(1)))
            state_d = ST_FROZEN;
      end
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         state_q     <= ST_IDLE;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         postCnt_q   <= '0;
         ts_q        <= '0;
         overflow_q  <= 1'b0;
         triggered_q <= 1'b0;
         drop_q      <= '0;
         rdValid_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         postCnt_q   <= postCnt_d;
         ts_q        <= ts_q + TS_W'(1);
         overflow_q  <= overflow_d;
         triggered_q <= triggered_d;
         drop_q      <= drop_d;
         rdValid_q   <= rdAccept;
      end
   end

   dzcpu_trace_buffer_ram #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) uRam (
      .iClock (iClock),
      .iReset (iReset),
      .iWe    (wrEn),
      .iWaddr (wrPtr_q),
      .iWdata (wrEntry),
      .iRe    (rdAccept),
      .iRaddr (rdPtr_q),
      .oRdata (bus.oRdData)
   );

   assign bus.oRdValid   = rdValid_q;
   assign bus.oCount     = count_q;
   assign bus.oEmpty     = (count_q == '0);
   assign bus.oState     = state_q;
   assign bus.oOverflow  = overflow_q;
   assign bus.oTriggered = triggered_q;
   assign bus.oDropCount = drop_q;

endmodule

// File: tb/tb_dzcpu_trace_buffer.sv
// Directed self-checking bench for dzcpu_trace_buffer with default parameters.
module tb_dzcpu_trace_buffer;
   import dzcpu_trace_buffer_pkg::*;

   localparam int DEPTH = 64, NUM_CH = 2, DATA_W = 32, TS_W = 16;

   logic iClock = 1'b0;
   logic iReset = 1'b1;
   int testsRun = 0;
   int testsFailed = 0;
   logic [15:0] ts0;

   dzcpu_trace_buffer_if #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TS_W(TS_W)) bus ();

   dzcpu_trace_buffer #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TS_W(TS_W)) dut (
      .iClock (iClock),
      .iReset (iReset),
      .bus    (bus)
   );

   always #5 iClock = ~iClock;

   // Entry layout {ts[48:33], ch[32], payload[31:0]}.
   function automatic logic [31:0] payloadOf(input logic [48:0] e);
      return e[31:0];
   endfunction
   function automatic logic chOf(input logic [48:0] e);
      return e[32];
   endfunction
   function automatic logic [15:0] tsOf(input logic [48:0] e);
      return e[48:33];
   endfunction

   task automatic tick();
      @(posedge iClock);
      #1;
   endtask

   task automatic clearInputs();
      bus.iEvent = '0; bus.iPayload = '0; bus.iArm = 0; bus.iDisarm = 0;
      bus.iTrigger = 0; bus.iPostCount = '0; bus.iStopOnFull = 0; bus.iRdReq = 0;
   endtask

   task automatic pulseArm();
      bus.iArm = 1; tick(); bus.iArm = 0;
   endtask

   task automatic pulseDisarm();
      bus.iDisarm = 1; tick(); bus.iDisarm = 0;
   endtask

   task automatic test_reset();
      clearInputs();
      iReset = 1;
      tick(); tick();
      testsRun++;
      if (bus.oState !== 2'd0 || bus.oCount !== 7'd0 || bus.oEmpty !== 1'b1 || bus.oRdValid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_ctrl got state=%0d count=%0d empty=%0b valid=%0b expected 0/0/1/0",
                  bus.oState, bus.oCount, bus.oEmpty, bus.oRdValid);
      end
      testsRun++;
      if (bus.oRdData !== '0 || bus.oOverflow !== 1'b0 || bus.oTriggered !== 1'b0 || bus.oDropCount !== 8'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags got data=%0h ovf=%0b trg=%0b drop=%0d expected all 0",
                  bus.oRdData, bus.oOverflow, bus.oTriggered, bus.oDropCount);
      end
      iReset = 0;
      tick();
   endtask

   task automatic test_basic_capture();
      logic [31:0] expPay [3] = '{32'h11, 32'h22, 32'h33};
      pulseArm();
      testsRun++;
      if (bus.oState !== 2'd1) begin
         testsFailed++; $display("[TB] FAIL basic_armed got %0d expected 1", bus.oState);
      end
      for (int i = 0; i < 3; i++) begin
         bus.iEvent = 2'b01; bus.iPayload = {32'h0, expPay[i]};
         tick();
         testsRun++;
         if (bus.oCount !== 7'(i + 1)) begin
            testsFailed++; $display("[TB] FAIL basic_count%0d got %0d expected %0d", i, bus.oCount, i + 1);
         end
      end
      bus.iEvent = '0;
      pulseDisarm();
      testsRun++;
      if (bus.oState !== 2'd0 || bus.oCount !== 7'd3) begin
         testsFailed++; $display("[TB] FAIL basic_disarm got state=%0d count=%0d expected 0/3", bus.oState, bus.oCount);
      end
      bus.iTrigger = 1; tick(); bus.iTrigger = 0;
      testsRun++;
      if (bus.oState !== 2'd0 || bus.oTriggered !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL idle_trigger got state=%0d trg=%0b expected 0/0", bus.oState, bus.oTriggered);
      end
      bus.iRdReq = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 0) ts0 = tsOf(bus.oRdData);
         testsRun++;
         if (bus.oRdValid !== 1'b1 || payloadOf(bus.oRdData) !== expPay[i] || chOf(bus.oRdData) !== 1'(CH_CPU_EOF)
             || tsOf(bus.oRdData) !== ts0 + 16'(i)) begin
            testsFailed++;
            $display("[TB] FAIL basic_pop%0d got valid=%0b pay=%0h ch=%0d ts=%0d expected 1/%0h/0/%0d",
                     i, bus.oRdValid, payloadOf(bus.oRdData), chOf(bus.oRdData), tsOf(bus.oRdData), expPay[i], ts0 + 16'(i));
         end
      end
      testsRun++;
      if (bus.oEmpty !== 1'b1 || bus.oCount !== 7'd0) begin
         testsFailed++; $display("[TB] FAIL basic_empty got empty=%0b count=%0d expected 1/0", bus.oEmpty, bus.oCount);
      end
      tick();
      bus.iRdReq = 0;
      testsRun++;
      if (bus.oRdValid !== 1'b0 || payloadOf(bus.oRdData) !== 32'h33) begin
         testsFailed++; $display("[TB] FAIL empty_pop got valid=%0b pay=%0h expected 0/33", bus.oRdValid, payloadOf(bus.oRdData));
      end
   endtask

   task automatic test_circular_overflow();
      pulseArm();
      for (int i = 1; i <= 70; i++) begin
         bus.iEvent = 2'b10; bus.iPayload = {32'(i), 32'h0};
         tick();
      end
      bus.iEvent = '0; bus.iTrigger = 1; bus.iPostCount = '0;
      tick();
      bus.iTrigger = 0;
      testsRun++;
      if (bus.oState !== 2'd3 || bus.oCount !== 7'd64 || bus.oOverflow !== 1'b1 || bus.oTriggered !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL circ_frozen got state=%0d count=%0d ovf=%0b trg=%0b expected 3/64/1/1",
                  bus.oState, bus.oCount, bus.oOverflow, bus.oTriggered);
      end
      bus.iRdReq = 1; tick(); bus.iRdReq = 0;
      testsRun++;
      if (bus.oRdValid !== 1'b1 || payloadOf(bus.oRdData) !== 32'd7 || chOf(bus.oRdData) !== 1'(CH_MMU_WR) || bus.oCount !== 7'd63) begin
         testsFailed++;
         $display("[TB] FAIL circ_pop got valid=%0b pay=%0d ch=%0d count=%0d expected 1/7/1/63",
                  bus.oRdValid, payloadOf(bus.oRdData), chOf(bus.oRdData), bus.oCount);
      end
   endtask

   task automatic test_drop_saturation();
      pulseArm();
      testsRun++;
      if (bus.oDropCount !== 8'd0 || bus.oOverflow !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL arm_clear got drop=%0d ovf=%0b expected 0/0", bus.oDropCount, bus.oOverflow);
      end
      bus.iEvent = 2'b11; bus.iPayload = {32'hD1, 32'hC0};
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (i == 10) begin
            testsRun++;
            if (bus.oDropCount !== 8'd10) begin
               testsFailed++; $display("[TB] FAIL drop_10 got %0d expected 10", bus.oDropCount);
            end
         end
      end
      bus.iEvent = '0;
      testsRun++;
      if (bus.oDropCount !== 8'd255) begin
         testsFailed++; $display("[TB] FAIL drop_sat got %0d expected 255", bus.oDropCount);
      end
      pulseDisarm();
      bus.iRdReq = 1; tick(); bus.iRdReq = 0;
      testsRun++;
      if (payloadOf(bus.oRdData) !== 32'hC0 || chOf(bus.oRdData) !== 1'b0 || bus.oCount !== 7'd63) begin
         testsFailed++;
         $display("[TB] FAIL drop_winner got pay=%0h ch=%0d count=%0d expected c0/0/63",
                  payloadOf(bus.oRdData), chOf(bus.oRdData), bus.oCount);
      end
   endtask

   task automatic test_post_trigger();
      pulseArm();
      bus.iTrigger = 1; bus.iPostCount = 7'd5;
      bus.iEvent = 2'b01; bus.iPayload = {32'h0, 32'h100};
      tick();
      bus.iTrigger = 0;
      testsRun++;
      if (bus.oState !== 2'd2 || bus.oCount !== 7'd1 || bus.oTriggered !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL post_enter got state=%0d count=%0d trg=%0b expected 2/1/1",
                                 bus.oState, bus.oCount, bus.oTriggered);
      end
      for (int i = 1; i <= 8; i++) begin
         bus.iPayload = {32'h0, 32'h100 + 32'(i)};
         tick();
         if (i == 4) begin
            testsRun++;
            if (bus.oState !== 2'd2 || bus.oCount !== 7'd5) begin
               testsFailed++; $display("[TB] FAIL post_4 got state=%0d count=%0d expected 2/5", bus.oState, bus.oCount);
            end
         end
         if (i == 5) begin
            testsRun++;
            if (bus.oState !== 2'd3 || bus.oCount !== 7'd6) begin
               testsFailed++; $display("[TB] FAIL post_5 got state=%0d count=%0d expected 3/6", bus.oState, bus.oCount);
            end
         end
      end
      bus.iEvent = '0;
      testsRun++;
      if (bus.oCount !== 7'd6) begin
         testsFailed++; $display("[TB] FAIL post_final got %0d expected 6", bus.oCount);
      end
      bus.iRdReq = 1; tick(); bus.iRdReq = 0;
      testsRun++;
      if (payloadOf(bus.oRdData) !== 32'h100) begin
         testsFailed++; $display("[TB] FAIL post_pop got %0h expected 100", payloadOf(bus.oRdData));
      end
   endtask

   task automatic test_stop_on_full();
      bus.iStopOnFull = 1;
      pulseArm();
      bus.iEvent = 2'b01; bus.iPayload = {32'h0, 32'h200};
      tick();
      bus.iEvent = '0; bus.iRdReq = 1;
      tick();
      bus.iRdReq = 0;
      testsRun++;
      if (bus.oRdValid !== 1'b0 || bus.oCount !== 7'd1) begin
         testsFailed++; $display("[TB] FAIL armed_pop got valid=%0b count=%0d expected 0/1", bus.oRdValid, bus.oCount);
      end
      for (int i = 1; i <= 64; i++) begin
         bus.iEvent = 2'b01; bus.iPayload = {32'h0, 32'h200 + 32'(i)};
         tick();
         if (i == 62) begin
            testsRun++;
            if (bus.oState !== 2'd1 || bus.oCount !== 7'd63) begin
               testsFailed++; $display("[TB] FAIL stop_63 got state=%0d count=%0d expected 1/63", bus.oState, bus.oCount);
            end
         end
         if (i == 63) begin
            testsRun++;
            if (bus.oState !== 2'd3 || bus.oCount !== 7'd64) begin
               testsFailed++; $display("[TB] FAIL stop_full got state=%0d count=%0d expected 3/64", bus.oState, bus.oCount);
            end
         end
      end
      bus.iEvent = '0;
      testsRun++;
      if (bus.oCount !== 7'd64 || bus.oOverflow !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL stop_65th got count=%0d ovf=%0b expected 64/0", bus.oCount, bus.oOverflow);
      end
      bus.iRdReq = 1;
      tick();
      testsRun++;
      if (bus.oRdValid !== 1'b1 || payloadOf(bus.oRdData) !== 32'h200) begin
         testsFailed++; $display("[TB] FAIL stop_pop got valid=%0b pay=%0h expected 1/200", bus.oRdValid, payloadOf(bus.oRdData));
      end
      @(posedge iClock);
      #2 iReset = 1;
      #1;
      testsRun++;
      if (bus.oRdValid !== 1'b0 || bus.oRdData !== '0 || bus.oCount !== 7'd0 || bus.oState !== 2'd0 || bus.oEmpty !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL midread_reset got valid=%0b data=%0h count=%0d state=%0d empty=%0b expected 0/0/0/0/1",
                  bus.oRdValid, bus.oRdData, bus.oCount, bus.oState, bus.oEmpty);
      end
      clearInputs();
      tick();
      iReset = 0;
   endtask

   initial begin
      clearInputs();
      test_reset();
      test_basic_capture();
      test_circular_overflow();
      test_drop_saturation();
      test_post_trigger();
      test_stop_on_full();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/dzcpu_trace_buffer.md
# dzcpu_trace_buffer

Synthesizable, parametrised on-chip trace capture for the pGB CPU/MMU subsystem. Records time-stamped events from up to NUM_CH sources (default: CPU end-of-flow register snapshot, MMU write) into a circular buffer. A trigger/post-trigger state machine freezes the buffer. A pop-style read port drains the frozen buffer.

## Interface
- DEPTH, 64: entries; power of 2, ≥4
- NUM_CH, 2: event channels; ≥1
- DATA_W, 32: payload bits per channel
- TS_W, 16: timestamp bits
- (derived) CH_W = max(1, clog2(NUM_CH)); ENTRY_W = TS_W + CH_W + DATA_W
- iClock  in  1  single clock; all logic on rising edge
- iReset  in  1  asynchronous, active-high reset
- iEvent  in  NUM_CH  per-channel event strobe, one cycle per event
- iPayload  in  NUM_CH*DATA_W  channel k payload at [k*DATA_W +: DATA_W]
- iArm  in  1  clear buffer/counters, start capture
- iDisarm  in  1  stop capture, keep contents, go IDLE
- iTrigger  in  1  trigger strobe
- iPostCount  in  clog2(DEPTH)+1  entries to capture after trigger entry
- iStopOnFull  in  1  1: freeze when full; 0: overwrite oldest
- iRdReq  in  1  pop oldest entry
- oRdData  out  ENTRY_W  {timestamp, channel, payload}
- oRdValid  out  1  one-cycle strobe qualifying oRdData
- oCount  out  clog2(DEPTH)+1  occupied entries
- oEmpty  out  1  oCount==0
- oState  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3
- oOverflow  out  1  sticky: an entry was overwritten since last arm
- oTriggered  out  1  sticky: trigger accepted since last arm
- oDropCount  out  8  saturating count of events lost to arbitration

## Operation
- Timestamp: TS_W-bit free-running counter, 0 after reset, wraps modulo 2^TS_W; sampled in the capture cycle.
- Arbitration: lowest-index asserted channel wins. Every other asserted channel increments oDropCount by one, saturating at 255. Drops are counted only in ARMED/POST.
- Capture occurs only in ARMED and POST. It writes {ts, winner index, winner payload} at wr pointer; wr advances modulo DEPTH.
- Full in circular mode (iStopOnFull=0): the write overwrites the oldest entry. rd advances with wr, oCount stays DEPTH, oOverflow sets.
- Full in stop mode: a write that makes oCount==DEPTH forces FROZEN on the next edge. That write is kept.
- State transitions:
  - IDLE --iArm--> ARMED
  - ARMED --iTrigger--> POST, with post counter = iPostCount. If iPostCount==0 → FROZEN.
  - POST: each capture decrements the counter. A capture with counter==1 → FROZEN.
  - FROZEN --iArm--> ARMED
  - any state --iDisarm--> IDLE
- The trigger-cycle event, if present, is captured as the trigger entry. It does not consume the post count.
- Priority: iArm > iDisarm > trigger/full/post logic. Arm while ARMED/POST restarts: pointers, oCount, flags and oDropCount clear, and the event of that cycle is not captured.
- iTrigger outside ARMED is ignored.
- Read: iRdReq in IDLE or FROZEN with !oEmpty pops the oldest entry: rd advances and oCount decrements. iRdReq when empty or in ARMED/POST is ignored (no oRdValid).

## Timing
- Reset: state IDLE, pointers 0, oCount 0, oEmpty 1, oRdData 0, oRdValid 0, oOverflow/oTriggered 0, oDropCount 0, timestamp 0. Reset mid-operation discards contents logically; RAM contents are don't-care.
- Event in cycle N is reflected in oCount at N+1. State change is visible at N+1.
- Read: iRdReq at N → oRdData/oRdValid at N+1 (synchronous RAM read). Back-to-back requests give one entry per cycle.
- oRdValid low whenever no accepted request occurred in the previous cycle. oRdData holds its last value.

## Structure
- Shared defs file dzcpu_trace_defs holds:
  - state encodings
  - channel IDs: CH_CPU_EOF=0, CH_MMU_WR=1
  - ENTRY_W/CH_W derivation macros
- Sub-module trace_ram: simple dual-port, DEPTH×ENTRY_W, one write port, registered read port; infers block RAM.
- Top holds FSM, pointers, arbiter, counters.

## Test plan
- Reset, arm, 3 events on ch0 (payloads 0x11,0x22,0x33), disarm, 3 pops → entries in order, channel 0, strictly increasing timestamps; oEmpty=1 after third.
- DEPTH=64, iStopOnFull=0, arm, 70 events, trigger with iPostCount=0 → FROZEN; oCount=64, oOverflow=1, first pop payload = 7th event.
- Same cycle ch0 and ch1 asserted 300 times → only ch0 captured, oDropCount=255 (saturated).
- Trigger with iPostCount=5, then 8 events → FROZEN after 5th; oCount=6 (trigger entry + 5), oTriggered=1.
- iStopOnFull=1, 64 events → FROZEN, 65th event not stored; pop during ARMED ignored; iReset asserted mid-read → all outputs at reset values within same cycle.
